// File: rtl/snd_dmactrl.sv
// Playback DMA controller: bursts sample words from memory into the I2S sample FIFO and sequences
// converter commands. Define SND_DMACTRL_STAT_EN to add the STAT_UNDERRUN counter output.
module snd_dmactrl #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned CMD_HOLD   = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        CTRL_START,
    input  logic        CTRL_PAUSE,
    input  logic        CTRL_STOP,
    input  logic [31:0] CFG_BASEADDR,
    input  logic [28:0] CFG_DATASIZE,
    input  logic        CFG_LOOP,
    output logic        RD_REQ,
    output logic [31:0] RD_ADDR,
    output logic [7:0]  RD_LEN,
    input  logic        RD_ACK,
    input  logic        RD_VALID,
    input  logic [31:0] RD_DATA,
    input  logic        RD_LAST,
    input  logic [10:0] FIFO_WRCNT,
    output logic        FIFO_WR,
    output logic [31:0] FIFO_DIN,
    output logic        FIFO_RST,
    output logic [1:0]  SND_COMMAND,
    output logic [28:0] SND_DATASIZE,
    output logic        SND_LOOP,
    output logic        STATUS_BUSY,
    output logic        STATUS_PAUSED,
    output logic        DONE_IRQ
`ifdef SND_DMACTRL_STAT_EN
    ,
    output logic [15:0] STAT_UNDERRUN
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StData,
        StWait,
        StPause,
        StFlush
    } state_e;

    localparam logic [1:0]  CmdNone    = 2'b00;
    localparam logic [1:0]  CmdPlay    = 2'b01;
    localparam logic [1:0]  CmdPause   = 2'b10;
    localparam logic [1:0]  CmdReset   = 2'b11;
    localparam logic [10:0] FillMax    = 11'(FIFO_DEPTH - BURST_LEN);
    localparam logic [28:0] BurstWords = 29'(BURST_LEN);
    localparam logic [7:0]  BurstLenM1 = 8'(BURST_LEN - 1);
    localparam logic [15:0] HoldInit   = 16'(CMD_HOLD - 1);

    state_e      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] base_q, base_d;
    logic [28:0] rem_q, rem_d;
    logic [28:0] size_q, size_d;
    logic        loop_q, loop_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic        wr_q, wr_d;
    logic [31:0] din_q, din_d;
    logic        done_q, done_d;
    logic        stop_pend_q, stop_pend_d;
    logic        pause_pend_q, pause_pend_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [1:0]  cmd_q;
    logic [15:0] hold_q;
    logic        issue;
    logic [1:0]  issue_code;
    logic [7:0]  len_next;
    logic        stop_eff;
    logic        pause_eff;

    assign len_next  = (rem_q >= BurstWords) ? BurstLenM1 : 8'(rem_q[7:0] - 8'd1);
    assign stop_eff  = stop_pend_q | CTRL_STOP;
    assign pause_eff = pause_pend_q | CTRL_PAUSE;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        base_d       = base_q;
        rem_d        = rem_q;
        size_d       = size_q;
        loop_d       = loop_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wr_d         = 1'b0;
        din_d        = din_q;
        done_d       = 1'b0;
        stop_pend_d  = stop_pend_q;
        pause_pend_d = pause_pend_q;
        flush_cnt_d  = flush_cnt_q;
        issue        = 1'b0;
        issue_code   = CmdNone;

        unique case (state_q)
            StIdle: begin
                if (CTRL_START) begin
                    size_d     = CFG_DATASIZE;
                    loop_d     = CFG_LOOP;
                    base_d     = CFG_BASEADDR;
                    ptr_d      = CFG_BASEADDR;
                    rem_d      = CFG_DATASIZE;
                    issue      = 1'b1;
                    issue_code = CmdPlay;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (CTRL_STOP) begin
                    issue       = 1'b1;
                    issue_code  = CmdReset;
                    flush_cnt_d = 2'd0;
                    state_d     = StFlush;
                end else if (CTRL_PAUSE) begin
                    issue      = 1'b1;
                    issue_code = CmdPause;
                    state_d    = StPause;
                end else if (rem_q != 29'd0) begin
                    if (FIFO_WRCNT <= FillMax) begin
                        addr_d  = ptr_q;
                        len_d   = len_next;
                        state_d = StReq;
                    end
                end else if (loop_q) begin
                    ptr_d = base_q;
                    rem_d = size_q;
                end else if (FIFO_WRCNT == 11'd0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StReq: begin
                // An ack in the same cycle as a request means the burst is already committed.
                if (RD_ACK) begin
                    stop_pend_d  = CTRL_STOP;
                    pause_pend_d = CTRL_PAUSE;
                    state_d      = StData;
                end else if (CTRL_STOP) begin
                    issue       = 1'b1;
                    issue_code  = CmdReset;
                    flush_cnt_d = 2'd0;
                    state_d     = StFlush;
                end else if (CTRL_PAUSE) begin
                    issue      = 1'b1;
                    issue_code = CmdPause;
                    state_d    = StPause;
                end
            end
            StData: begin
                stop_pend_d  = stop_eff;
                pause_pend_d = pause_eff;
                if (RD_VALID) begin
                    ptr_d = ptr_q + 32'd4;
                    if (rem_q != 29'd0) begin
                        rem_d = rem_q - 29'd1;
                    end
                    wr_d  = ~stop_eff;
                    din_d = RD_DATA;
                    if (RD_LAST) begin
                        stop_pend_d  = 1'b0;
                        pause_pend_d = 1'b0;
                        if (stop_eff) begin
                            issue       = 1'b1;
                            issue_code  = CmdReset;
                            flush_cnt_d = 2'd0;
                            state_d     = StFlush;
                        end else if (pause_eff) begin
                            issue      = 1'b1;
                            issue_code = CmdPause;
                            state_d    = StPause;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StPause: begin
                if (CTRL_STOP) begin
                    issue       = 1'b1;
                    issue_code  = CmdReset;
                    flush_cnt_d = 2'd0;
                    state_d     = StFlush;
                end else if (CTRL_START && !CTRL_PAUSE) begin
                    issue      = 1'b1;
                    issue_code = CmdPlay;
                    state_d    = StWait;
                end
            end
            StFlush: begin
                if (flush_cnt_q == 2'd2) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= StIdle;
            ptr_q        <= 32'd0;
            base_q       <= 32'd0;
            rem_q        <= 29'd0;
            size_q       <= 29'd0;
            loop_q       <= 1'b0;
            addr_q       <= 32'd0;
            len_q        <= 8'd0;
            wr_q         <= 1'b0;
            din_q        <= 32'd0;
            done_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            flush_cnt_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            base_q       <= base_d;
            rem_q        <= rem_d;
            size_q       <= size_d;
            loop_q       <= loop_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            wr_q         <= wr_d;
            din_q        <= din_d;
            done_q       <= done_d;
            stop_pend_q  <= stop_pend_d;
            pause_pend_q <= pause_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // A newly issued command always restarts the hold window.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cmd_q  <= CmdNone;
            hold_q <= 16'd0;
        end else if (issue) begin
            cmd_q  <= issue_code;
            hold_q <= HoldInit;
        end else if (cmd_q != CmdNone) begin
            if (hold_q == 16'd0) begin
                cmd_q <= CmdNone;
            end else begin
                hold_q <= hold_q - 16'd1;
            end
        end
    end

`ifdef SND_DMACTRL_STAT_EN
    logic [15:0] underrun_q;
    logic        underrun_inc;

    assign underrun_inc = (state_q != StIdle) && (state_q != StPause) && (state_q != StFlush) &&
                          (rem_q != 29'd0) && (FIFO_WRCNT == 11'd0);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            underrun_q <= 16'd0;
        end else if (state_q == StIdle && CTRL_START) begin
            underrun_q <= 16'd0;
        end else if (underrun_inc && underrun_q != 16'hFFFF) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign STAT_UNDERRUN = underrun_q;
`endif

    assign RD_REQ        = (state_q == StReq);
    assign RD_ADDR       = addr_q;
    assign RD_LEN        = len_q;
    assign FIFO_WR       = wr_q;
    assign FIFO_DIN      = din_q;
    assign FIFO_RST      = (state_q == StFlush);
    assign SND_COMMAND   = cmd_q;
    assign SND_DATASIZE  = size_q;
    assign SND_LOOP      = loop_q;
    assign STATUS_BUSY   = (state_q != StIdle);
    assign STATUS_PAUSED = (state_q == StPause);
    assign DONE_IRQ      = done_q;

endmodule

// File: tb/tb_snd_dmactrl.sv
// Directed self-checking bench for snd_dmactrl: burst sequencing, loop, FIFO threshold,
// pause/stop handling, command hold and asynchronous reset.
module tb_snd_dmactrl;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        CTRL_START = 1'b0;
    logic        CTRL_PAUSE = 1'b0;
    logic        CTRL_STOP = 1'b0;
    logic [31:0] CFG_BASEADDR = 32'd0;
    logic [28:0] CFG_DATASIZE = 29'd0;
    logic        CFG_LOOP = 1'b0;
    logic        RD_REQ;
    logic [31:0] RD_ADDR;
    logic [7:0]  RD_LEN;
    logic        RD_ACK = 1'b0;
    logic        RD_VALID = 1'b0;
    logic [31:0] RD_DATA = 32'd0;
    logic        RD_LAST = 1'b0;
    logic [10:0] FIFO_WRCNT = 11'd0;
    logic        FIFO_WR;
    logic [31:0] FIFO_DIN;
    logic        FIFO_RST;
    logic [1:0]  SND_COMMAND;
    logic [28:0] SND_DATASIZE;
    logic        SND_LOOP;
    logic        STATUS_BUSY;
    logic        STATUS_PAUSED;
    logic        DONE_IRQ;
`ifdef SND_DMACTRL_STAT_EN
    logic [15:0] STAT_UNDERRUN;
`endif

    snd_dmactrl dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .CTRL_START    (CTRL_START),
        .CTRL_PAUSE    (CTRL_PAUSE),
        .CTRL_STOP     (CTRL_STOP),
        .CFG_BASEADDR  (CFG_BASEADDR),
        .CFG_DATASIZE  (CFG_DATASIZE),
        .CFG_LOOP      (CFG_LOOP),
        .RD_REQ        (RD_REQ),
        .RD_ADDR       (RD_ADDR),
        .RD_LEN        (RD_LEN),
        .RD_ACK        (RD_ACK),
        .RD_VALID      (RD_VALID),
        .RD_DATA       (RD_DATA),
        .RD_LAST       (RD_LAST),
        .FIFO_WRCNT    (FIFO_WRCNT),
        .FIFO_WR       (FIFO_WR),
        .FIFO_DIN      (FIFO_DIN),
        .FIFO_RST      (FIFO_RST),
        .SND_COMMAND   (SND_COMMAND),
        .SND_DATASIZE  (SND_DATASIZE),
        .SND_LOOP      (SND_LOOP),
        .STATUS_BUSY   (STATUS_BUSY),
        .STATUS_PAUSED (STATUS_PAUSED),
        .DONE_IRQ      (DONE_IRQ)
`ifdef SND_DMACTRL_STAT_EN
        ,
        .STAT_UNDERRUN (STAT_UNDERRUN)
`endif
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int wr_n = 0;
    int done_n = 0;
    int frst_n = 0;
    logic [31:0] last_din = 32'd0;

    always @(posedge ACLK) begin
        if (FIFO_WR) begin
            wr_n++;
            last_din = FIFO_DIN;
        end
        if (DONE_IRQ) done_n++;
        if (FIFO_RST) frst_n++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!RD_REQ && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_req"}, 64'(RD_REQ), 64'd1);
    endtask

    // Serve one burst; pause_at raises CTRL_PAUSE with that beat, stop_at inserts an idle
    // cycle before that beat carrying STOP, PAUSE and START together.
    task automatic do_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input int pause_at, input int stop_at);
        wait_req(tag, 20);
        check_eq({tag, "_addr"}, 64'(RD_ADDR), 64'(addr));
        check_eq({tag, "_len"}, 64'(RD_LEN), 64'(len));
        tick();
        check_eq({tag, "_hold"}, 64'({RD_REQ, RD_ADDR, RD_LEN}), 64'({1'b1, addr, len}));
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stop_at) begin
                RD_VALID   = 1'b0;
                RD_LAST    = 1'b0;
                CTRL_STOP  = 1'b1;
                CTRL_PAUSE = 1'b1;
                CTRL_START = 1'b1;
                tick();
                CTRL_STOP  = 1'b0;
                CTRL_PAUSE = 1'b0;
                CTRL_START = 1'b0;
            end
            RD_VALID   = 1'b1;
            RD_DATA    = 32'hD000_0000 | (addr + 32'(4 * i));
            RD_LAST    = (i == int'(len));
            CTRL_PAUSE = (i == pause_at);
            tick();
        end
        RD_VALID   = 1'b0;
        RD_LAST    = 1'b0;
        CTRL_PAUSE = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [28:0] size, input logic lp);
        CFG_BASEADDR = base;
        CFG_DATASIZE = size;
        CFG_LOOP     = lp;
        CTRL_START   = 1'b1;
        tick();
        CTRL_START   = 1'b0;
    endtask

    int wr_base;
    int frst_base;
    int n;

    initial begin
        #12;
        check_eq("reset_ctrl", 64'({RD_REQ, FIFO_WR, FIFO_RST, STATUS_BUSY, STATUS_PAUSED,
                                    DONE_IRQ, SND_COMMAND, SND_LOOP}), 64'd0);
        check_eq("reset_data", 64'({RD_ADDR, RD_LEN, FIFO_DIN}), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        tick();

        // Non-loop run held off by a nearly full FIFO, then three bursts.
        FIFO_WRCNT = 11'd1009;
        start_run(32'h1000, 29'd40, 1'b0);
        check_eq("cmd_play", 64'(SND_COMMAND), 64'd1);
        check_eq("busy_on", 64'(STATUS_BUSY), 64'd1);
        check_eq("datasize", 64'({SND_LOOP, SND_DATASIZE}), 64'(29'd40));
        repeat (15) tick();
        check_eq("cmd_hold16", 64'(SND_COMMAND), 64'd1);
        check_eq("no_req_1009", 64'(RD_REQ), 64'd0);
        tick();
        check_eq("cmd_expired", 64'(SND_COMMAND), 64'd0);
        FIFO_WRCNT = 11'd1008;
        wait_req("thr1008", 2);
        FIFO_WRCNT = 11'd0;
        do_burst("b1", 32'h1000, 8'd15, -1, -1);
        do_burst("b2", 32'h1040, 8'd15, -1, -1);
        do_burst("b3", 32'h1080, 8'd7, -1, -1);
        FIFO_WRCNT = 11'd5;
        repeat (4) tick();
        check_eq("drain_busy", 64'(STATUS_BUSY), 64'd1);
        check_eq("drain_nodone", 64'(done_n), 64'd0);
        FIFO_WRCNT = 11'd0;
        n = 0;
        while (STATUS_BUSY && n < 5) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check_eq("done_once", 64'(done_n), 64'd1);
        check_eq("idle_after", 64'(STATUS_BUSY), 64'd0);
        check_eq("wr_total", 64'(wr_n), 64'd40);
        check_eq("last_din", 64'(last_din), 64'h0000_0000_D000_109C);

        // Loop run with a pause in the third burst, then resume and stop mid-burst.
        start_run(32'h1000, 29'd20, 1'b1);
        wr_base = wr_n;
        do_burst("b4", 32'h1000, 8'd15, -1, -1);
        do_burst("b5", 32'h1040, 8'd3, -1, -1);
        do_burst("b6", 32'h1000, 8'd15, 4, -1);
        check_eq("pause_cmd", 64'(SND_COMMAND), 64'd2);
        check_eq("paused", 64'(STATUS_PAUSED), 64'd1);
        repeat (3) tick();
        check_eq("pause_noreq", 64'({RD_REQ, STATUS_PAUSED}), 64'b01);
        check_eq("loop_writes", 64'(wr_n - wr_base), 64'd36);
        check_eq("loop_nodone", 64'(done_n), 64'd1);
        start_run(32'hFFFF_0000, 29'd7, 1'b0);
        check_eq("resume_cmd", 64'({SND_COMMAND, STATUS_PAUSED}), 64'b010);
        check_eq("cfg_kept", 64'({SND_LOOP, SND_DATASIZE}), 64'({1'b1, 29'd20}));
        wr_base = wr_n;
        frst_base = frst_n;
        do_burst("b7", 32'h1040, 8'd3, -1, 2);
        check_eq("stop_cmd", 64'(SND_COMMAND), 64'd3);
        check_eq("stop_rst", 64'(FIFO_RST), 64'd1);
        repeat (4) tick();
        check_eq("flush_len", 64'(frst_n - frst_base), 64'd3);
        check_eq("stop_writes", 64'(wr_n - wr_base), 64'd2);
        check_eq("flush_idle", 64'({STATUS_BUSY, STATUS_PAUSED, FIFO_RST}), 64'd0);

        // Pause/stop are ignored while idle.
        CTRL_PAUSE = 1'b1;
        CTRL_STOP  = 1'b1;
        tick();
        CTRL_PAUSE = 1'b0;
        CTRL_STOP  = 1'b0;
        tick();
        check_eq("idle_ignore", 64'({STATUS_BUSY, FIFO_RST}), 64'd0);

        // Stalled request with an empty FIFO, then stop before ack.
        start_run(32'h2000, 29'd40, 1'b0);
        repeat (10) tick();
        check_eq("stall_req", 64'({RD_REQ, RD_ADDR}), 64'({1'b1, 32'h2000}));
`ifdef SND_DMACTRL_STAT_EN
        check_eq("underrun", 64'(STAT_UNDERRUN), 64'd10);
`endif
        CTRL_STOP = 1'b1;
        tick();
        CTRL_STOP = 1'b0;
        check_eq("req_stop", 64'({SND_COMMAND, FIFO_RST, RD_REQ}), 64'b1110);
        repeat (3) tick();
        check_eq("req_stop_idle", 64'(STATUS_BUSY), 64'd0);

        // Asynchronous reset with a request outstanding.
        start_run(32'h3000, 29'd8, 1'b0);
        wait_req("pre_rst", 5);
        #2;
        ARESETN = 1'b0;
        #1;
        check_eq("async_rst", 64'({RD_REQ, STATUS_BUSY, SND_COMMAND, RD_ADDR}), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        check_eq("post_rst", 64'({RD_REQ, STATUS_BUSY}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
